// File: rtl/mem_stage_pkg.sv
// Shared defines for the memory stage: register bus widths, funct3 access sizes,
// FSM state encodings and the natural-alignment helper.
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef RegDataBus
`define RegDataBus 31:0
`endif

package mem_stage_pkg;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

   // Byte offset truncated to the natural alignment of the access size.
   // Unknown funct3 codes are handled as word accesses.
   function automatic logic [1:0] nat_off(input logic [2:0] size, input logic [1:0] off);
      case (size)
         MEM_B, MEM_BU: nat_off = off;
         MEM_H, MEM_HU: nat_off = {off[1], 1'b0};
         default:       nat_off = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit data bus: store byte enables and lane replication,
// load lane extraction with sign/zero extension. Purely combinational.
module mem_lane_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  off,
   input  logic [31:0] store_data,
   input  logic [31:0] load_raw,
   output logic [3:0]  be,
   output logic [31:0] store_lanes,
   output logic [31:0] load_data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      be          = 4'hF;
      store_lanes = store_data;
      case (size)
         MEM_B, MEM_BU: begin
            be          = 4'b0001 << off;
            store_lanes = {4{store_data[7:0]}};
         end
         MEM_H, MEM_HU: begin
            be          = 4'b0011 << off;
            store_lanes = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      lane_b = load_raw[7:0];
      case (off)
         2'd1:    lane_b = load_raw[15:8];
         2'd2:    lane_b = load_raw[23:16];
         2'd3:    lane_b = load_raw[31:24];
         default: lane_b = load_raw[7:0];
      endcase
      lane_h = off[1] ? load_raw[31:16] : load_raw[15:0];
   end

   always_comb begin
      load_data = load_raw;
      case (size)
         MEM_B:   load_data = {{24{lane_b[7]}}, lane_b};
         MEM_H:   load_data = {{16{lane_h[15]}}, lane_h};
         MEM_BU:  load_data = {24'b0, lane_b};
         MEM_HU:  load_data = {16'b0, lane_h};
         default: load_data = load_raw;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: single-outstanding req/ack data bus, stall while in flight,
// one-cycle result toward mem_wb. Optional MEM_MISALIGN_TRAP_EN faults misaligned H/W.
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef RegDataBus
`define RegDataBus 31:0
`endif

module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              ex_wreg_en_i,
   input  logic [`RegAddrBus] ex_wreg_addr_i,
   input  logic [`RegDataBus] ex_wreg_data_i,
   input  logic              ex_mem_re_i,
   input  logic              ex_mem_we_i,
   input  logic [2:0]        ex_mem_size_i,
   input  logic [ADDR_W-1:0] ex_mem_addr_i,
   input  logic [DATA_W-1:0] ex_mem_wdata_i,
   output logic              mem_wreg_en_o,
   output logic [`RegAddrBus] mem_wreg_addr_o,
   output logic [`RegDataBus] mem_wreg_data_o,
   output logic              stallreq_o,
   output logic              fault_o,
   output logic              dbus_req_o,
   output logic              dbus_we_o,
   output logic [ADDR_W-1:0] dbus_addr_o,
   output logic [3:0]        dbus_be_o,
   output logic [DATA_W-1:0] dbus_wdata_o,
   input  logic              dbus_ack_i,
   input  logic [DATA_W-1:0] dbus_rdata_i
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   mem_state_e         state;
   logic [CNT_W-1:0]   cnt;
   logic               res_en;
   logic [`RegAddrBus] res_addr;
   logic [`RegDataBus] res_data;
   logic               fault_q;

   logic               mem_op;
   logic               is_store;
   logic               misal;
   logic [1:0]         off;
   logic [3:0]         be;
   logic [31:0]        store_lanes;
   logic [31:0]        load_data;

   assign mem_op   = ex_mem_re_i | ex_mem_we_i;
   assign is_store = ex_mem_we_i;
   assign off      = nat_off(ex_mem_size_i, ex_mem_addr_i[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
   assign misal = mem_op && (off != ex_mem_addr_i[1:0]);
`else
   assign misal = 1'b0;
`endif

   mem_lane_align u_align (
      .size        (ex_mem_size_i),
      .off         (off),
      .store_data  (ex_mem_wdata_i),
      .load_raw    (dbus_rdata_i),
      .be          (be),
      .store_lanes (store_lanes),
      .load_data   (load_data)
   );

   // Result registers are loaded on the cycle that leaves the access (ack, timeout or trap)
   // and presented during DONE; the ex_* inputs may move on once stall drops.
   always_ff @(posedge clk) begin
      if (nrst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         res_en   <= 1'b0;
         res_addr <= '0;
         res_data <= '0;
         fault_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               fault_q <= 1'b0;
               cnt     <= '0;
               if (mem_op) begin
                  res_addr <= ex_wreg_addr_i;
                  if (misal) begin
                     state    <= ST_DONE;
                     res_en   <= 1'b0;
                     res_data <= '0;
                     fault_q  <= 1'b1;
                  end else if (dbus_ack_i) begin
                     state    <= ST_DONE;
                     res_en   <= ex_wreg_en_i & ~is_store;
                     res_data <= is_store ? '0 : load_data;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (dbus_ack_i) begin
                  state    <= ST_DONE;
                  cnt      <= '0;
                  res_en   <= ex_wreg_en_i & ~is_store;
                  res_data <= is_store ? '0 : load_data;
               end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  state    <= ST_DONE;
                  cnt      <= '0;
                  res_en   <= 1'b0;
                  res_data <= '0;
                  fault_q  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               state   <= ST_IDLE;
               fault_q <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Every output is gated by reset so a reset mid-access drops req in the same cycle.
   always_comb begin
      mem_wreg_en_o   = 1'b0;
      mem_wreg_addr_o = '0;
      mem_wreg_data_o = '0;
      stallreq_o      = 1'b0;
      fault_o         = 1'b0;
      dbus_req_o      = 1'b0;
      dbus_we_o       = 1'b0;
      dbus_addr_o     = '0;
      dbus_be_o       = '0;
      dbus_wdata_o    = '0;
      if (!nrst) begin
         case (state)
            ST_IDLE: begin
               if (!mem_op) begin
                  mem_wreg_en_o   = ex_wreg_en_i;
                  mem_wreg_addr_o = ex_wreg_addr_i;
                  mem_wreg_data_o = ex_wreg_data_i;
               end else begin
                  stallreq_o = 1'b1;
                  dbus_req_o = ~misal;
               end
            end
            ST_WAIT: begin
               stallreq_o = 1'b1;
               dbus_req_o = 1'b1;
            end
            ST_DONE: begin
               mem_wreg_en_o   = res_en;
               mem_wreg_addr_o = res_addr;
               mem_wreg_data_o = res_data;
               fault_o         = fault_q;
            end
            default: ;
         endcase
         if (dbus_req_o) begin
            dbus_we_o    = is_store;
            dbus_addr_o  = {ex_mem_addr_i[ADDR_W-1:2], 2'b00};
            dbus_be_o    = be;
            dbus_wdata_o = store_lanes;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writeback pushed per op, popped on the output cycle.
module tb_mem_stage;

   localparam int TMO = 255;
`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        nrst;
   logic        ex_wreg_en_i;
   logic [4:0]  ex_wreg_addr_i;
   logic [31:0] ex_wreg_data_i;
   logic        ex_mem_re_i, ex_mem_we_i;
   logic [2:0]  ex_mem_size_i;
   logic [31:0] ex_mem_addr_i, ex_mem_wdata_i;
   logic        mem_wreg_en_o;
   logic [4:0]  mem_wreg_addr_o;
   logic [31:0] mem_wreg_data_o;
   logic        stallreq_o, fault_o, dbus_req_o, dbus_we_o;
   logic [31:0] dbus_addr_o, dbus_wdata_o;
   logic [3:0]  dbus_be_o;
   logic        dbus_ack_i;
   logic [31:0] dbus_rdata_i;

   mem_stage #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .nrst(nrst),
      .ex_wreg_en_i(ex_wreg_en_i), .ex_wreg_addr_i(ex_wreg_addr_i), .ex_wreg_data_i(ex_wreg_data_i),
      .ex_mem_re_i(ex_mem_re_i), .ex_mem_we_i(ex_mem_we_i), .ex_mem_size_i(ex_mem_size_i),
      .ex_mem_addr_i(ex_mem_addr_i), .ex_mem_wdata_i(ex_mem_wdata_i),
      .mem_wreg_en_o(mem_wreg_en_o), .mem_wreg_addr_o(mem_wreg_addr_o), .mem_wreg_data_o(mem_wreg_data_o),
      .stallreq_o(stallreq_o), .fault_o(fault_o),
      .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
      .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
      .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        flt;
   } res_t;

   res_t q[$];
   logic op_live = 1'b0;
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic mis_model(input logic [2:0] sz, input logic [31:0] a);
      case (sz)
         3'b001, 3'b101: return a[0];
         3'b010:         return a[1:0] != 2'b00;
         default:        return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ld_model(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] s;
      case (sz)
         3'b000, 3'b100: s = rd >> (8 * a[1:0]);
         3'b001, 3'b101: s = rd >> (16 * a[1]);
         default:        s = rd;
      endcase
      case (sz)
         3'b000:  return 32'($signed(s[7:0]));
         3'b001:  return 32'($signed(s[15:0]));
         3'b100:  return {24'h0, s[7:0]};
         3'b101:  return {16'h0, s[15:0]};
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] be_model(input logic [2:0] sz, input logic [31:0] a);
      case (sz)
         3'b000, 3'b100: return 4'b0001 << a[1:0];
         3'b001, 3'b101: return a[1] ? 4'b1100 : 4'b0011;
         default:        return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] wd_model(input logic [2:0] sz, input logic [31:0] d);
      case (sz)
         3'b000, 3'b100: return {d[7:0], d[7:0], d[7:0], d[7:0]};
         3'b001, 3'b101: return {d[15:0], d[15:0]};
         default:        return d;
      endcase
   endfunction

   // Monitor: the first non-stalled cycle of a live op is its output cycle.
   always @(negedge clk) begin
      res_t e;
      #2;
      if (op_live && !stallreq_o && q.size() > 0) begin
         e = q.pop_front();
         chk("wreg_en", 64'(mem_wreg_en_o), 64'(e.en));
         chk("fault", 64'(fault_o), 64'(e.flt));
         if (e.en) begin
            chk("wreg_addr", 64'(mem_wreg_addr_o), 64'(e.addr));
            chk("wreg_data", 64'(mem_wreg_data_o), 64'(e.data));
         end
      end
   end

   task automatic idle();
      @(negedge clk);
      op_live = 1'b0;
      ex_wreg_en_i = 1'b0; ex_wreg_addr_i = '0; ex_wreg_data_i = '0;
      ex_mem_re_i = 1'b0; ex_mem_we_i = 1'b0; ex_mem_size_i = 3'b010;
      ex_mem_addr_i = '0; ex_mem_wdata_i = '0; dbus_ack_i = 1'b0;
   endtask

   // ack_dly < 0: the bus never answers.
   task automatic do_op(input logic re, input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] wa, input logic [31:0] wdat,
                        input int ack_dly, input logic [31:0] rd);
      res_t e;
      logic memop, mis, tmo;
      int nst, exp_st, k;
      memop = re | we;
      mis   = TRAP && memop && mis_model(sz, a);
      tmo   = memop && !mis && ack_dly < 0;
      if (!memop)          e = '{1'b1, wa, wdat, 1'b0};
      else if (mis || tmo) e = '{1'b0, wa, 32'h0, 1'b1};
      else if (we)         e = '{1'b0, wa, 32'h0, 1'b0};
      else                 e = '{1'b1, wa, ld_model(sz, a, rd), 1'b0};
      exp_st = !memop ? 0 : mis ? 1 : tmo ? TMO + 1 : ack_dly + 1;
      q.push_back(e);
      @(negedge clk);
      ex_wreg_en_i = 1'b1; ex_wreg_addr_i = wa; ex_wreg_data_i = wdat;
      ex_mem_re_i = re; ex_mem_we_i = we; ex_mem_size_i = sz;
      ex_mem_addr_i = a; ex_mem_wdata_i = wd;
      op_live = 1'b1;
      nst = 0;
      k = 0;
      while (1) begin
         dbus_ack_i   = (k == ack_dly);
         dbus_rdata_i = (k == ack_dly) ? rd : $urandom;
         #1;
         if (k == 0 && memop && !mis) begin
            chk("bus_we", 64'(dbus_we_o), 64'(we));
            chk("bus_addr", 64'(dbus_addr_o), 64'({a[31:2], 2'b00}));
            if (we) begin
               chk("bus_be", 64'(dbus_be_o), 64'(be_model(sz, a)));
               chk("bus_wdata", 64'(dbus_wdata_o), 64'(wd_model(sz, wd)));
            end
         end
         if (!stallreq_o) begin
            chk("req_out", 64'(dbus_req_o), 64'h0);
            break;
         end
         chk("req_stall", 64'(dbus_req_o), 64'(!mis));
         nst++;
         k++;
         if (k > 600) begin
            chk("stall_bound", 64'(k), 64'(exp_st));
            break;
         end
         @(negedge clk);
      end
      dbus_ack_i = 1'b0;
      chk("stall_cycles", 64'(nst), 64'(exp_st));
   endtask

   initial begin
      logic [2:0] szs [5];
      szs = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      nrst = 1'b1;
      ex_wreg_en_i = 1'b1; ex_wreg_addr_i = 5'd7; ex_wreg_data_i = 32'h5555AAAA;
      ex_mem_re_i = 1'b1; ex_mem_we_i = 1'b0; ex_mem_size_i = 3'b010;
      ex_mem_addr_i = 32'h40; ex_mem_wdata_i = 32'h0; dbus_ack_i = 1'b0; dbus_rdata_i = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_en", 64'(mem_wreg_en_o), 64'h0);
      chk("rst_data", 64'(mem_wreg_data_o), 64'h0);
      chk("rst_stall", 64'(stallreq_o), 64'h0);
      chk("rst_req", 64'(dbus_req_o), 64'h0);
      chk("rst_fault", 64'(fault_o), 64'h0);
      idle();
      nrst = 1'b0;

      do_op(0, 0, 3'b010, 32'h0, 32'h0, 5'd5, 32'h1234, 0, 32'h0);
      do_op(1, 0, 3'b010, 32'h100, 32'h0, 5'd1, 32'h0, 3, 32'hDEADBEEF);
      do_op(1, 0, 3'b000, 32'h103, 32'h0, 5'd2, 32'h0, 0, 32'h80000000);
      do_op(1, 0, 3'b100, 32'h103, 32'h0, 5'd3, 32'h0, 1, 32'h80000000);
      do_op(1, 0, 3'b001, 32'h102, 32'h0, 5'd4, 32'h0, 0, 32'h80015A5A);
      do_op(1, 0, 3'b101, 32'h102, 32'h0, 5'd6, 32'h0, 2, 32'h80015A5A);
      do_op(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 5'd8, 32'h0, 1, 32'h0);
      do_op(0, 1, 3'b000, 32'h101, 32'h000000C3, 5'd9, 32'h0, 2, 32'h0);
      do_op(1, 1, 3'b010, 32'h104, 32'hCAFEF00D, 5'd10, 32'h0, 0, 32'h0);
      do_op(1, 0, 3'b010, 32'h102, 32'h0, 5'd11, 32'h0, 1, 32'h01020304);
      do_op(1, 0, 3'b001, 32'h103, 32'h0, 5'd12, 32'h0, 0, 32'hF00D1234);
      do_op(1, 0, 3'b010, 32'h108, 32'h0, 5'd13, 32'h0, -1, 32'h0);
      do_op(1, 0, 3'b010, 32'h10C, 32'h0, 5'd14, 32'h0, 0, 32'h13579BDF);
      for (int i = 0; i < 20; i++)
         do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), szs[$urandom_range(0, 4)],
               32'h200 + $urandom_range(0, 63), $urandom, 5'($urandom_range(1, 31)), $urandom,
               $urandom_range(0, 4), $urandom);
      idle();

      // Reset in the middle of an access, then a stray ack in IDLE.
      ex_mem_re_i = 1'b1; ex_mem_size_i = 3'b010; ex_mem_addr_i = 32'h300;
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      #1;
      chk("midrst_req_now", 64'(dbus_req_o), 64'h0);
      @(negedge clk);
      #1;
      chk("midrst_req", 64'(dbus_req_o), 64'h0);
      chk("midrst_stall", 64'(stallreq_o), 64'h0);
      chk("midrst_en", 64'(mem_wreg_en_o), 64'h0);
      idle();
      nrst = 1'b0;
      dbus_ack_i = 1'b1; dbus_rdata_i = 32'hFFFFFFFF;
      #1;
      chk("late_ack_req", 64'(dbus_req_o), 64'h0);
      @(negedge clk);
      dbus_ack_i = 1'b0;
      #1;
      chk("late_ack_stall", 64'(stallreq_o), 64'h0);
      chk("late_ack_fault", 64'(fault_o), 64'h0);
      do_op(1, 0, 3'b000, 32'h301, 32'h0, 5'd15, 32'h0, 1, 32'h00007F00);
      idle();
      repeat (2) @(negedge clk);
      chk("queue_empty", 64'(q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
